logic_unit: RTL and testbench

- Parametrised, registered successor to the team's two-input gate primitives.
- Applies one of the NOT/AND/OR/XOR/NAND/NOR/XNOR functions to WIDTH-bit vectors, selected per transaction by an opcode.
- Streaming valid/ready handshake on input and output.
- Accumulate mode folds the selected function across a multi-beat burst and emits one result.
- Sits between datapath producers and consumers wherever a selectable bitwise stage is needed.

---
 rtl/logic_unit_pkg.sv | 41 ++++
 rtl/logic_unit_fn.sv | 22 ++
 rtl/logic_unit.sv | 167 ++++++++++++++++
 tb/tb_logic_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared op encoding, FSM states and the bitwise function used by logic_unit.
// apply_op works at LU_MAX_W bits; callers zero-extend operands and keep the low WIDTH bits.
package logic_unit_pkg;

  // Upper bound on the WIDTH parameter of any logic_unit instance.
  localparam int unsigned LU_MAX_W = 1024;

  typedef enum logic [2:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_XOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  function automatic logic [LU_MAX_W-1:0] apply_op(input op_e                 op,
                                                   input logic [LU_MAX_W-1:0] a,
                                                   input logic [LU_MAX_W-1:0] b);
    logic [LU_MAX_W-1:0] y;
    case (op)
      OP_NOT:  y = ~a;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      default: y = '0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/logic_unit_fn.sv
// Combinational bitwise function select; zero latency, no flow control.
// NOT returns ~a, the reserved op returns all zeros.
module logic_unit_fn import logic_unit_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [LU_MAX_W-1:0] y_full;
  logic                unused_hi;

  always_comb begin
    y_full = apply_op(op, LU_MAX_W'(a), LU_MAX_W'(b));
  end

  assign y         = y_full[WIDTH-1:0];
  assign unused_hi = ^y_full[LU_MAX_W-1:WIDTH];

endmodule

// File: rtl/logic_unit.sv
// Registered selectable bitwise stage with burst fold; latency 1, one output register, in_ready = !out_valid || out_ready.
// Optional LOGIC_UNIT_POPCOUNT_EN adds a pop output registered alongside s.
module logic_unit import logic_unit_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int CW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             mode,
  input  logic             last,
  input  logic [WIDTH-1:0] e1,
  input  logic [WIDTH-1:0] e2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic [CW-1:0]    beats,
  output logic             err
`ifdef LOGIC_UNIT_POPCOUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] pop
`endif
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CW-1:0]    beats_q, beats_d;
  logic             err_q, err_d;

  op_e              op_in;
  logic             in_fire;
  logic [WIDTH-1:0] first_val;
  logic [CW-1:0]    cnt_inc;
  op_e              fn_op;
  logic [WIDTH-1:0] fn_a, fn_b, fn_y;

  assign op_in     = op_e'(op);
  assign in_ready  = !out_valid_q || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign first_val = (op_in == OP_NOT) ? ~e1 : e1;
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  // Inside a burst the fold runs on (acc, e1); NOT ignores the accumulator.
  always_comb begin
    fn_op = op_in;
    fn_a  = e1;
    fn_b  = e2;
    if (state_q == ACCUM) begin
      fn_op = op_q;
      fn_a  = (op_q == OP_NOT) ? e1 : acc_q;
      fn_b  = e1;
    end
  end

  logic_unit_fn #(.WIDTH(WIDTH)) u_fn (
    .op (fn_op),
    .a  (fn_a),
    .b  (fn_b),
    .y  (fn_y)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q && !out_ready;
    s_d         = s_q;
    beats_d     = beats_q;
    err_d       = err_q;
    if (in_fire) begin
      unique case (state_q)
        IDLE: begin
          if (!mode) begin
            out_valid_d = 1'b1;
            s_d         = fn_y;
            beats_d     = CW'(1);
            err_d       = (op_in == OP_RSVD);
          end else begin
            op_d  = op_in;
            acc_d = first_val;
            cnt_d = CW'(1);
            if (last) begin
              out_valid_d = 1'b1;
              s_d         = (op_in == OP_RSVD) ? '0 : first_val;
              beats_d     = CW'(1);
              err_d       = (op_in == OP_RSVD);
            end else begin
              state_d = ACCUM;
            end
          end
        end
        ACCUM: begin
          acc_d = fn_y;
          cnt_d = cnt_inc;
          if (last) begin
            out_valid_d = 1'b1;
            s_d         = fn_y;
            beats_d     = cnt_inc;
            err_d       = (op_q == OP_RSVD);
            state_d     = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_NOT;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      s_q         <= '0;
      beats_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      beats_q     <= beats_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign beats     = beats_q;
  assign err       = err_q;

`ifdef LOGIC_UNIT_POPCOUNT_EN
  localparam int PW = $clog2(WIDTH + 1);

  logic [PW-1:0] pop_q, pop_d;

  // s_d already holds s_q when nothing loads, so pop tracks s under backpressure.
  always_comb begin
    pop_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_d = pop_d + PW'(s_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pop_q <= '0;
    end else begin
      pop_q <= pop_d;
    end
  end

  assign pop = pop_q;
`endif

endmodule

// File: tb/tb_logic_unit.sv
// Bench for logic_unit: directed cases with literal results, then random traffic against a burst/queue model.
module tb_logic_unit;

  localparam int W   = 8;
  localparam int CW  = 16;
  localparam int CW2 = 2;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic [2:0]     op;
  logic           mode;
  logic           last;
  logic [W-1:0]   e1;
  logic [W-1:0]   e2;
  logic           out_ready;

  logic           in_ready, out_valid, err;
  logic [W-1:0]   s;
  logic [CW-1:0]  beats;
  logic           in_ready2, out_valid2, err2;
  logic [W-1:0]   s2;
  logic [CW2-1:0] beats2;

  int n_chk;
  int n_fail;
  bit chk_en;

  // Reference state: the pending result and the beats of the open burst.
  bit             m_valid;
  logic [W-1:0]   m_s;
  int             m_cnt;
  bit             m_err;
  bit             m_burst;
  int             m_bop;
  logic [W-1:0]   m_q[$];

  logic_unit #(.WIDTH(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .mode(mode), .last(last), .e1(e1), .e2(e2),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .beats(beats), .err(err)
  );

  // Narrow counter copy so that saturation is reached by ordinary bursts.
  logic_unit #(.WIDTH(W), .CW(CW2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .op(op), .mode(mode), .last(last), .e1(e1), .e2(e2),
    .out_valid(out_valid2), .out_ready(out_ready), .s(s2), .beats(beats2), .err(err2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] ref_f(input int o, input logic [W-1:0] a, input logic [W-1:0] b);
    case (o)
      0:       return ~a;
      1:       return a & b;
      2:       return a | b;
      3:       return a ^ b;
      4:       return ~(a & b);
      5:       return ~(a | b);
      6:       return ~(a ^ b);
      default: return '0;
    endcase
  endfunction

  function automatic int sat(input int n, input int cw);
    int lim;
    lim = (1 << cw) - 1;
    return (n > lim) ? lim : n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit           acc_b;
    logic [W-1:0] a;
    if (rst) begin
      m_valid = 0;
      m_s     = '0;
      m_cnt   = 0;
      m_err   = 0;
      m_burst = 0;
      m_q.delete();
    end else begin
      acc_b = in_valid && (!m_valid || out_ready);
      if (m_valid && out_ready) m_valid = 0;
      if (acc_b) begin
        if (!m_burst && !mode) begin
          m_valid = 1;
          m_s     = ref_f(int'(op), e1, e2);
          m_cnt   = 1;
          m_err   = (op == 3'd7);
        end else begin
          if (!m_burst) begin
            m_burst = 1;
            m_bop   = int'(op);
            m_q.delete();
          end
          m_q.push_back(e1);
          if (last) begin
            a = (m_bop == 0) ? ~m_q[0] : m_q[0];
            for (int i = 1; i < m_q.size(); i++)
              a = (m_bop == 0) ? ~m_q[i] : ref_f(m_bop, a, m_q[i]);
            if (m_bop == 7) a = '0;
            m_valid = 1;
            m_s     = a;
            m_cnt   = m_q.size();
            m_err   = (m_bop == 7);
            m_burst = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, !m_valid || out_ready);
      chk("out_valid", out_valid, m_valid);
      chk("sat_out_valid", out_valid2, m_valid);
      if (m_valid) begin
        chk("s", s, m_s);
        chk("beats", beats, sat(m_cnt, CW));
        chk("err", err, m_err);
        chk("sat_s", s2, m_s);
        chk("sat_beats", beats2, sat(m_cnt, CW2));
        chk("sat_err", err2, m_err);
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send(input logic [2:0] o, input logic md, input logic lst,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    bit rdy;
    op = o; mode = md; last = lst; e1 = a; e2 = b; in_valid = 1'b1;
    rdy = 0;
    for (int k = 0; k < 20 && !rdy; k++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
    end
    if (!rdy) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: actual in_ready 0 required 1 within 20 cycles");
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [W-1:0] sv,
                            input int bv, input logic ev);
    @(negedge clk);
    chk({name, "_valid"}, out_valid, v);
    if (v) begin
      chk({name, "_s"}, s, sv);
      chk({name, "_beats"}, beats, bv);
      chk({name, "_err"}, err, ev);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; chk_en = 0;
    rst = 1'b1; in_valid = 1'b0; op = '0; mode = 1'b0; last = 1'b0;
    e1 = '0; e2 = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1;

    @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_s", s, 8'h00);
    chk("rst_beats", beats, 0);
    chk("rst_err", err, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    send(3'd1, 1'b0, 1'b0, 8'hF0, 8'h3C);
    expect_out("and", 1'b1, 8'h30, 1, 1'b0);

    send(3'd2, 1'b1, 1'b0, 8'h01, 8'h00);
    expect_out("or_b1", 1'b0, 8'h00, 0, 1'b0);
    send(3'd2, 1'b1, 1'b0, 8'h02, 8'h00);
    expect_out("or_b2", 1'b0, 8'h00, 0, 1'b0);
    send(3'd2, 1'b1, 1'b1, 8'h04, 8'h00);
    expect_out("or_acc", 1'b1, 8'h07, 3, 1'b0);

    send(3'd4, 1'b1, 1'b0, 8'hFF, 8'h00);
    send(3'd1, 1'b1, 1'b1, 8'h0F, 8'h00);
    expect_out("nand_acc", 1'b1, 8'hF0, 2, 1'b0);

    send(3'd6, 1'b1, 1'b1, 8'h5A, 8'h00);
    expect_out("one_beat", 1'b1, 8'h5A, 1, 1'b0);

    send(3'd0, 1'b1, 1'b0, 8'h12, 8'h00);
    send(3'd0, 1'b1, 1'b1, 8'h34, 8'h00);
    expect_out("not_acc", 1'b1, 8'hCB, 2, 1'b0);

    out_ready = 1'b0;
    send(3'd3, 1'b0, 1'b0, 8'h12, 8'h34);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_s", s, 8'h26);
      chk("bp_beats", beats, 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(3'd1, 1'b0, 1'b0, 8'hFF, 8'h0F);
    expect_out("bp_new", 1'b1, 8'h0F, 1, 1'b0);

    send(3'd7, 1'b0, 1'b0, 8'hAA, 8'h55);
    expect_out("rsvd", 1'b1, 8'h00, 1, 1'b1);
    send(3'd3, 1'b0, 1'b0, 8'hAA, 8'h55);
    expect_out("after_rsvd", 1'b1, 8'hFF, 1, 1'b0);

    send(3'd7, 1'b1, 1'b0, 8'h33, 8'h00);
    send(3'd2, 1'b1, 1'b1, 8'h44, 8'h00);
    expect_out("rsvd_acc", 1'b1, 8'h00, 2, 1'b1);

    send(3'd2, 1'b1, 1'b0, 8'h11, 8'h00);
    send(3'd2, 1'b1, 1'b0, 8'h22, 8'h00);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_s", s, 8'h00);
    @(posedge clk);
    #1;
    send(3'd3, 1'b0, 1'b0, 8'h0F, 8'hFF);
    expect_out("post_rst", 1'b1, 8'hF0, 1, 1'b0);

    repeat (3000) begin
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      op        = 3'($urandom_range(0, 7));
      mode      = 1'($urandom_range(0, 1));
      last      = ($urandom_range(0, 3) == 0);
      e1        = 8'($urandom);
      e2        = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
